hazard_forward_ctrl: RTL

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It replaces the stand-alone forwarding unit and the two 3-input operand muxes. It adds:
- load-use stall detection with a configurable load latency
- taken-branch flush
- optional saturating performance counters

Sits between the ID/EX register and the ALU, and drives the write-enables of the PC and IF/ID registers.

---
 rtl/hazard_forward_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: EX operand forwarding, load-use stall FSM and taken-branch flush.
// Saturating stall/flush counters exist only when HAZARD_PERF_CNT_EN is defined.
module hazard_forward_ctrl #(
    parameter int REG_AW   = 5,
    parameter int DATA_W   = 64,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              br_taken,
    input  logic [DATA_W-1:0] ex_rdata1,
    input  logic [DATA_W-1:0] ex_rdata2,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic [DATA_W-1:0] ex_opa,
    output logic [DATA_W-1:0] ex_opb,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    localparam int LW = $clog2(LOAD_LAT + 1);
    localparam logic [0:0] RUN = 1'b0, STALL = 1'b1;
    logic [0:0]    state_q, state_d;
    logic [LW-1:0] left_q, left_d;
    logic          lu, stall, flush;
    logic          mem_a, mem_b, wb_a, wb_b;

    // EX/MEM hits are checked first so the youngest producer wins
    always_comb begin
        mem_a     = mem_regwrite && mem_rd != '0 && mem_rd == ex_rs1;
        mem_b     = mem_regwrite && mem_rd != '0 && mem_rd == ex_rs2;
        wb_a      = wb_regwrite && wb_rd != '0 && wb_rd == ex_rs1;
        wb_b      = wb_regwrite && wb_rd != '0 && wb_rd == ex_rs2;
        forward_a = reset ? 2'b00 : mem_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
        forward_b = reset ? 2'b00 : mem_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
        ex_opa    = forward_a == 2'b10 ? mem_result : forward_a == 2'b01 ? wb_data : ex_rdata1;
        ex_opb    = forward_b == 2'b10 ? mem_result : forward_b == 2'b01 ? wb_data : ex_rdata2;
    end

    always_comb begin
        lu          = id_valid && ex_memread && ex_regwrite && ex_rd != '0 &&
                      (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
        flush       = !reset && br_taken;
        stall       = !reset && !br_taken && (state_q == STALL || lu);
        pc_write    = !stall;
        ifid_write  = !stall;
        idex_bubble = stall;
        flush_ifid  = flush;
        flush_idex  = flush;
        flush_exmem = flush;
    end

    // A taken branch aborts any stall in progress
    always_comb begin
        state_d = RUN;
        left_d  = '0;
        if (!br_taken && state_q == STALL) begin
            left_d  = left_q - 1'b1;
            state_d = left_q == LW'(1) ? RUN : STALL;
        end else if (!br_taken && lu && LOAD_LAT > 1) begin
            left_d  = LW'(LOAD_LAT - 1);
            state_d = STALL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = idex_bubble && stall_cnt_q != '1 ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = br_taken && flush_cnt_q != '1 ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif
endmodule
